// File: rtl/rv32_pkg.sv
// rv32_pkg: RV32I opcode constants, immediate formats and the decode-slot
// state encoding shared by id_stage and imm_gen.
package rv32_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;

  typedef enum logic [1:0] {IDLE, READ, VALID} id_state_t;

  // Immediate layout selected by the major opcode; unknown opcodes carry none.
  function automatic imm_fmt_t imm_fmt(input logic [6:0] op);
    imm_fmt_t f;
    case (op)
      OP_LUI, OP_AUIPC:                                    f = FMT_U;
      OP_JAL:                                              f = FMT_J;
      OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM, OP_MISC_MEM:  f = FMT_I;
      OP_BRANCH:                                           f = FMT_B;
      OP_STORE:                                            f = FMT_S;
      default:                                             f = FMT_R;
    endcase
    return f;
  endfunction

  // Every RV32I major opcode ends in 2'b11, so an exact match on all seven
  // bits also rejects compressed/short encodings.
  function automatic logic is_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_OPIMM, OP_OP, OP_SYSTEM, OP_MISC_MEM: ok = 1'b1;
      default:                                           ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32I immediate extraction and sign extension.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  // Reassemble the scattered immediate bits for the instruction's format.
  always_comb begin
    imm = '0;
    case (imm_fmt(instr[6:0]))
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with a single holding slot, a one-cycle
// synchronous register-file read wait and a busy-bit scoreboard.
// Optional feature macro: ID_ILLEGAL_TRAP_EN adds the ex_illegal output;
// without it illegal encodings decode as a NOP.
module id_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rf_rs1,
  output logic [4:0]      rf_rs2,
  input  logic [XLEN-1:0] rf_rs1data,
  input  logic [XLEN-1:0] rf_rs2data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_pc,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_rs1data,
  output logic [XLEN-1:0] ex_rs2data
`ifdef ID_ILLEGAL_TRAP_EN
  ,
  output logic            ex_illegal
`endif
);
  import rv32_pkg::*;

  id_state_t       state, state_n;
  logic [NREG-1:0] busy, busy_n;

  logic [6:0]  dec_op;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_legal, dec_uses_rs1, dec_uses_rs2, dec_writes_rd;
  logic        hazard, accept;

  assign dec_op  = if_instr[6:0];
  assign dec_rd  = if_instr[11:7];
  assign dec_rs1 = if_instr[19:15];
  assign dec_rs2 = if_instr[24:20];

  // Illegal encodings use no sources and write nothing, so they can never
  // stall on, or mark, the scoreboard.
  assign dec_legal     = is_legal(dec_op);
  assign dec_uses_rs1  = dec_legal && !(dec_op == OP_LUI || dec_op == OP_AUIPC || dec_op == OP_JAL);
  assign dec_uses_rs2  = dec_legal && (dec_op == OP_BRANCH || dec_op == OP_STORE || dec_op == OP_OP);
  assign dec_writes_rd = dec_legal && !(dec_op == OP_BRANCH || dec_op == OP_STORE) && (dec_rd != 5'd0);

  // Registered busy bits only: a write completing this cycle is not forwarded.
  assign hazard = (dec_uses_rs1  && busy[dec_rs1]) ||
                  (dec_uses_rs2  && busy[dec_rs2]) ||
                  (dec_writes_rd && busy[dec_rd]);

  imm_gen u_imm_gen (
    .instr (if_instr),
    .imm   (dec_imm)
  );

  assign ex_valid   = (state == VALID);
  assign ex_rs1data = rf_rs1data;
  assign ex_rs2data = rf_rs2data;

  // Slot state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Accept condition and slot sequencing; flush overrides everything.
  always_comb begin
    state_n  = state;
    if_ready = 1'b0;
    if (!rst)
      if_ready = (state == IDLE || (state == VALID && ex_ready)) && !hazard && !flush;
    accept = if_valid && if_ready;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_n = READ;
        READ:    if (!wb_valid) state_n = VALID;  // RF only reads on non-write cycles
        VALID:   if (ex_ready) state_n = accept ? READ : IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Scoreboard next value: clears first, then a same-edge set wins.
  always_comb begin
    busy_n = busy;
    if (wb_valid)
      busy_n[wb_rd] = 1'b0;
    if (flush && state != IDLE && ex_rd_we)
      busy_n[ex_rd] = 1'b0;
    if (accept && dec_writes_rd)
      busy_n[dec_rd] = 1'b1;
    busy_n[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_n;
  end

  // Holding slot: decoded fields captured on accept and held until replaced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_pc       <= '0;
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
      ex_rd       <= '0;
      ex_rd_we    <= 1'b0;
      ex_imm      <= '0;
      rf_rs1      <= '0;
      rf_rs2      <= '0;
    end else if (accept) begin
      ex_pc       <= if_pc;
      ex_opcode   <= dec_op;
      ex_funct3   <= if_instr[14:12];
      ex_funct7b5 <= if_instr[30];
      ex_rd       <= dec_rd;
      ex_rd_we    <= dec_writes_rd;
      ex_imm      <= dec_imm;
      rf_rs1      <= dec_rs1;
      rf_rs2      <= dec_rs2;
    end
  end

`ifdef ID_ILLEGAL_TRAP_EN
  // Illegal flag travels with the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ex_illegal <= 1'b0;
    else if (accept) ex_illegal <= !dec_legal;
  end
`endif

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed stimulus for id_stage with a behavioural slot /
// scoreboard model, a small register file, and a per-cycle compare process.
module tb_id_stage;

  logic        clk, rst;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rs1data, rf_rs2data;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_imm, ex_rs1data, ex_rs2data;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_rd_we;
  logic [4:0]  ex_rd;
`ifdef ID_ILLEGAL_TRAP_EN
  logic        ex_illegal;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  id_stage dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rs1data(rf_rs1data), .rf_rs2data(rf_rs2data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .ex_imm(ex_imm), .ex_rs1data(ex_rs1data),
`ifdef ID_ILLEGAL_TRAP_EN
    .ex_illegal(ex_illegal),
`endif
    .ex_rs2data(ex_rs2data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- register file: synchronous read, skipped on write cycles
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) regs[k] <= 32'(k * 256);
      rf_rs1data <= '0;
      rf_rs2data <= '0;
    end else if (wb_valid) begin
      if (wb_rd != 5'd0) regs[wb_rd] <= wb_data;
    end else begin
      rf_rs1data <= regs[rf_rs1];
      rf_rs2data <= regs[rf_rs2];
    end
  end

  // ---------------- behavioural decode
  function automatic bit m_legal(input logic [31:0] i);
    case (i[6:0])
      7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h0F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_use1(input logic [31:0] i);
    return m_legal(i) && !(i[6:0] inside {7'h37, 7'h17, 7'h6F});
  endfunction

  function automatic bit m_use2(input logic [31:0] i);
    return m_legal(i) && (i[6:0] inside {7'h63, 7'h23, 7'h33});
  endfunction

  function automatic bit m_wr(input logic [31:0] i);
    return m_legal(i) && !(i[6:0] inside {7'h63, 7'h23}) && (i[11:7] != 5'd0);
  endfunction

  // Immediate built with signed shifts and masks on the whole word.
  function automatic logic [31:0] m_imm(input logic [31:0] i);
    int s;
    s = $signed(i);
    case (i[6:0])
      7'h37, 7'h17:               return i & 32'hFFFFF000;
      7'h67, 7'h03, 7'h13, 7'h73, 7'h0F: return 32'(s >>> 20);
      7'h23: return (32'(s >>> 20) & 32'hFFFFFFE0) | ((i >> 7) & 32'h1F);
      7'h63: return (32'(s >>> 19) & 32'hFFFFF000) | ((i << 4) & 32'h800) |
                    ((i >> 20) & 32'h7E0) | ((i >> 7) & 32'h1E);
      7'h6F: return (32'(s >>> 11) & 32'hFFF00000) | (i & 32'h000FF000) |
                    ((i >> 9) & 32'h800) | ((i >> 20) & 32'h7FE);
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- slot / scoreboard model
  bit          m_full, m_pres;
  bit          m_busy [32];
  logic [31:0] m_instr, m_pc, m_op1, m_op2;

  function automatic bit exp_ready();
    bit hz;
    hz = (m_use1(if_instr) && m_busy[if_instr[19:15]]) ||
         (m_use2(if_instr) && m_busy[if_instr[24:20]]) ||
         (m_wr(if_instr)   && m_busy[if_instr[11:7]]);
    return !rst && !flush && !hz && (!m_full || (m_pres && ex_ready));
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit acc;
    if (rst) begin
      m_full = 1'b0;
      m_pres = 1'b0;
      for (int k = 0; k < 32; k++) m_busy[k] = 1'b0;
    end else begin
      acc = if_valid && exp_ready();
      if (wb_valid) m_busy[wb_rd] = 1'b0;
      if (flush && m_full && m_wr(m_instr)) m_busy[m_instr[11:7]] = 1'b0;
      if (acc && m_wr(if_instr)) m_busy[if_instr[11:7]] = 1'b1;
      m_busy[0] = 1'b0;
      if (flush) m_full = 1'b0;
      else if (m_full && !m_pres) begin
        if (!wb_valid) begin
          m_pres = 1'b1;
          m_op1  = regs[m_instr[19:15]];
          m_op2  = regs[m_instr[24:20]];
        end
      end else if (m_full && m_pres && ex_ready) m_full = 1'b0;
      if (acc) begin
        m_full  = 1'b1;
        m_pres  = 1'b0;
        m_instr = if_instr;
        m_pc    = if_pc;
      end
    end
  end

  // ---------------- per-cycle compare on the falling edge
  always @(negedge clk) begin
    chk1("if_ready", if_ready, exp_ready());
    chk1("ex_valid", ex_valid, m_full && m_pres);
    if (m_full) begin
      chk("rf_rs1", 32'(rf_rs1), 32'(m_instr[19:15]));
      chk("rf_rs2", 32'(rf_rs2), 32'(m_instr[24:20]));
    end
    if (m_full && m_pres) begin
      chk("ex_pc", ex_pc, m_pc);
      chk("ex_opcode", 32'(ex_opcode), 32'(m_instr[6:0]));
      chk("ex_funct3", 32'(ex_funct3), 32'(m_instr[14:12]));
      chk1("ex_funct7b5", ex_funct7b5, m_instr[30]);
      chk("ex_rd", 32'(ex_rd), 32'(m_instr[11:7]));
      chk1("ex_rd_we", ex_rd_we, m_wr(m_instr));
      chk("ex_imm", ex_imm, m_imm(m_instr));
      chk("ex_rs1data", ex_rs1data, m_op1);
      chk("ex_rs2data", ex_rs2data, m_op2);
`ifdef ID_ILLEGAL_TRAP_EN
      chk1("ex_illegal", ex_illegal, !m_legal(m_instr));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
  endtask

  // ---------------- directed stimulus
  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    feed(1'b0, 32'h0, 32'h0);

    // model decode pinned against hand-assembled encodings
    chk("pin_sw_imm",   m_imm(32'hFE20AE23), 32'hFFFFFFFC);
    chk("pin_lui_imm",  m_imm(32'h123454B7), 32'h12345000);
    chk("pin_beq_imm",  m_imm(32'hFE000CE3), 32'hFFFFFFF8);
    chk("pin_jal_imm",  m_imm(32'h001000EF), 32'h00000800);
    chk("pin_addi_imm", m_imm(32'h00700293), 32'h00000007);
    chk1("pin_x0_we",   m_wr(32'h00100013), 1'b0);

    step(); step();
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_ex_pc", ex_pc, 32'h0);
    chk("rst_ex_imm", ex_imm, 32'h0);
    chk("rst_ex_rd", 32'(ex_rd), 32'h0);

    // cycle 0: addi x5,x0,7
    rst = 1'b0;
    feed(1'b1, 32'h00700293, 32'h100);
    #1 chk1("t1_accept", if_ready, 1'b1);
    step(); feed(1'b0, 32'h0, 32'h0);
    #1 chk1("t1_c1_valid", ex_valid, 1'b0);
    step();
    chk1("t1_c2_valid", ex_valid, 1'b1);
    chk("t1_rd", 32'(ex_rd), 32'd5);
    chk("t1_imm", ex_imm, 32'd7);
    chk("t1_pc", ex_pc, 32'h100);
    chk1("t1_we", ex_rd_we, 1'b1);

    // cycle 2: add x6,x5,x5 stalls on busy x5
    feed(1'b1, 32'h00528333, 32'h104);
    #1 chk1("t2_stall", if_ready, 1'b0);
    repeat (2) begin step(); chk1("t2_stall", if_ready, 1'b0); end
    step(); wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
    #1 chk1("t2_stall_wb", if_ready, 1'b0);
    step(); wb_valid = 1'b0;
    #1 chk1("t2_release", if_ready, 1'b1);
    step(); feed(1'b0, 32'h0, 32'h0);
    step();
    chk("t2_rd", 32'(ex_rd), 32'd6);
    chk("t2_op1", ex_rs1data, 32'h55);
    chk("t2_op2", ex_rs2data, 32'h55);

    // cycle 8: addi x8,x5,1 with writebacks holding the read for 3 cycles
    feed(1'b1, 32'h00128413, 32'h108);
    #1 chk1("t3_accept", if_ready, 1'b1);
    step(); feed(1'b0, 32'h0, 32'h0); wb_valid = 1'b1; wb_rd = 5'd6; wb_data = 32'h66;
    step(); wb_rd = 5'd5; wb_data = 32'hA5;
    step(); wb_rd = 5'd5; wb_data = 32'hA6;
    step(); wb_valid = 1'b0;
    #1 chk1("t3_held", ex_valid, 1'b0);
    step();
    chk1("t3_valid", ex_valid, 1'b1);
    chk("t3_op1", ex_rs1data, 32'hA6);
    chk("t3_imm", ex_imm, 32'd1);

    // cycle 13: back-pressure for 4 cycles with sw x2,-4(x1) waiting
    ex_ready = 1'b0;
    feed(1'b1, 32'hFE20AE23, 32'h10C);
    #1 chk1("t4_blocked", if_ready, 1'b0);
    repeat (3) begin
      step();
      chk1("t4_blocked", if_ready, 1'b0);
      chk("t4_pc_stable", ex_pc, 32'h108);
      chk("t4_imm_stable", ex_imm, 32'd1);
    end
    step(); ex_ready = 1'b1;
    #1 chk1("t4_handoff", if_ready, 1'b1);
    step(); feed(1'b0, 32'h0, 32'h0);
    #1 chk1("t4_read", ex_valid, 1'b0);
    step();
    chk("t4_sw_imm", ex_imm, 32'hFFFFFFFC);
    chk1("t4_sw_we", ex_rd_we, 1'b0);
    chk("t4_sw_op1", ex_rs1data, 32'h100);
    chk("t4_sw_op2", ex_rs2data, 32'h200);

    // cycle 19: beq x0,x0,-8 then jal x1,0x800
    feed(1'b1, 32'hFE000CE3, 32'h110);
    step(); feed(1'b1, 32'h001000EF, 32'h114);
    #1 chk1("t5_read_busy", if_ready, 1'b0);
    step();
    chk("t5_beq_imm", ex_imm, 32'hFFFFFFF8);
    chk1("t5_jal_accept", if_ready, 1'b1);
    step(); feed(1'b0, 32'h0, 32'h0);
    step();
    chk("t5_jal_imm", ex_imm, 32'h800);
    chk1("t5_jal_we", ex_rd_we, 1'b1);

    // cycle 23: illegal opcode naming busy x1 as rs1 is not stalled
    feed(1'b1, 32'h0040A2FF, 32'h118);
    #1 chk1("t6_ill_accept", if_ready, 1'b1);
    step(); feed(1'b0, 32'h0, 32'h0);
    step();
    chk1("t6_ill_we", ex_rd_we, 1'b0);
`ifdef ID_ILLEGAL_TRAP_EN
    chk1("t6_ill_flag", ex_illegal, 1'b1);
`endif

    // cycle 25: lui x9 held in VALID, then flushed
    feed(1'b1, 32'h123454B7, 32'h11C);
    #1 chk1("t7_lui_accept", if_ready, 1'b1);
    step(); feed(1'b0, 32'h0, 32'h0); ex_ready = 1'b0;
    step();
    chk1("t7_lui_valid", ex_valid, 1'b1);
    chk("t7_lui_imm", ex_imm, 32'h12345000);
    step(); flush = 1'b1; feed(1'b1, 32'h00500593, 32'h120);
    #1 chk1("t7_flush_no_accept", if_ready, 1'b0);
    step(); flush = 1'b0; ex_ready = 1'b1; feed(1'b1, 32'h00148493, 32'h124);
    #1 chk1("t7_flushed", ex_valid, 1'b0);
    chk1("t7_x9_free", if_ready, 1'b1);
    step(); feed(1'b1, 32'h00100013, 32'h128);
    #1 chk1("t7_read_busy", if_ready, 1'b0);
    step();
    chk("t7_x9_op1", ex_rs1data, 32'h900);
    chk1("t8_x0_accept", if_ready, 1'b1);

    // addi x0,x0,1 then addi x13,x0,2 interrupted by reset in READ
    step(); feed(1'b0, 32'h0, 32'h0);
    step();
    chk1("t8_x0_we", ex_rd_we, 1'b0);
    chk("t8_x0_rd", 32'(ex_rd), 32'd0);
    feed(1'b1, 32'h00200693, 32'h12C);
    #1 chk1("t8_x13_accept", if_ready, 1'b1);
    step(); feed(1'b0, 32'h0, 32'h0); rst = 1'b1;
    #1 chk1("t9_rst_valid", ex_valid, 1'b0);
    chk1("t9_rst_ready", if_ready, 1'b0);
    chk("t9_rst_pc", ex_pc, 32'h0);
    step(); rst = 1'b0; feed(1'b1, 32'h00108093, 32'h130);
    #1 chk1("t9_busy_cleared", if_ready, 1'b1);
    step(); feed(1'b0, 32'h0, 32'h0);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
